// File: rtl/mpf_uart_word_loader.sv
// Packet loader behind the UART byte receiver: parses sync + 32-bit address + 32-bit data
// packets and issues one word write per valid packet on a req/ack port.
module mpf_uart_word_loader #(
    parameter int unsigned clock_frequency = 25000000,
    parameter int unsigned timeout_cycles  = clock_frequency / 100,
    parameter logic [7:0]  sync_byte       = 8'hA5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  byte_data,
    input  logic        byte_ready,
    output logic        bus_write_req,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_write_ack,
    output logic        busy,
    output logic        overrun,
    output logic [7:0]  drop_count
);

    localparam int CW = (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles + 1);
    localparam logic [CW-1:0] TMO_LOAD = CW'(timeout_cycles);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WRITE
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          req_q, req_d;
    logic          busy_q, busy_d;
    logic          ovr_q, ovr_d;
    logic [7:0]    drop_q, drop_d;
    logic          drop_inc;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        addr_d   = addr_q;
        data_d   = data_q;
        req_d    = req_q;
        ovr_d    = ovr_q;
        drop_inc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (byte_ready && byte_data == sync_byte) begin
                    state_d = ST_ADDR;
                    idx_d   = 2'd0;
                    tmo_d   = TMO_LOAD;
                end
            end

            ST_ADDR: begin
                if (byte_ready) begin
                    addr_d = {addr_q[23:0], byte_data};
                    idx_d  = idx_q + 2'd1;
                    tmo_d  = TMO_LOAD;
                    if (idx_q == 2'd3) begin
                        // The word-alignment check uses the byte being shifted in.
                        if (byte_data[1:0] != 2'b00) begin
                            drop_inc = 1'b1;
                            state_d  = ST_IDLE;
                            tmo_d    = '0;
                        end else begin
                            state_d = ST_DATA;
                            idx_d   = 2'd0;
                        end
                    end
                end else if (tmo_q <= CW'(1)) begin
                    drop_inc = 1'b1;
                    state_d  = ST_IDLE;
                    tmo_d    = '0;
                end else begin
                    tmo_d = tmo_q - CW'(1);
                end
            end

            ST_DATA: begin
                if (byte_ready) begin
                    data_d = {data_q[23:0], byte_data};
                    idx_d  = idx_q + 2'd1;
                    tmo_d  = TMO_LOAD;
                    if (idx_q == 2'd3) begin
                        state_d = ST_WRITE;
                        req_d   = 1'b1;
                        idx_d   = 2'd0;
                        tmo_d   = '0;
                    end
                end else if (tmo_q <= CW'(1)) begin
                    drop_inc = 1'b1;
                    state_d  = ST_IDLE;
                    tmo_d    = '0;
                end else begin
                    tmo_d = tmo_q - CW'(1);
                end
            end

            ST_WRITE: begin
                // Bytes arriving here are flagged and discarded, never parsed as sync.
                if (byte_ready) begin
                    ovr_d = 1'b1;
                end
                if (bus_write_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        drop_d = drop_q;
        if (drop_inc && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            tmo_q   <= '0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            drop_q  <= drop_d;
        end
    end

    assign bus_write_req = req_q;
    assign bus_addr      = addr_q;
    assign bus_wdata     = data_q;
    assign busy          = busy_q;
    assign overrun       = ovr_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_mpf_uart_word_loader.sv
// Directed bench for mpf_uart_word_loader: inputs change and outputs are sampled on the
// falling clock edge; the DUT runs with a 20-cycle inter-byte timeout.
module tb_mpf_uart_word_loader;

    logic        clock;
    logic        reset_n;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        bus_write_req;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_write_ack;
    logic        busy;
    logic        overrun;
    logic [7:0]  drop_count;

    int errors = 0;
    int checks = 0;

    mpf_uart_word_loader #(
        .clock_frequency(2000),
        .timeout_cycles (20),
        .sync_byte      (8'hA5)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .bus_write_req(bus_write_req),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_write_ack(bus_write_ack),
        .busy         (busy),
        .overrun      (overrun),
        .drop_count   (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called on a falling edge; returns on the falling edge after the byte was sampled.
    task automatic send_byte(input logic [7:0] b);
        byte_data  = b;
        byte_ready = 1'b1;
        @(negedge clock);
        byte_ready = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic send_packet(input logic [31:0] a, input logic [31:0] d);
        send_byte(8'hA5);
        for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
    endtask

    task automatic do_reset();
        byte_ready    = 1'b0;
        byte_data     = 8'h00;
        bus_write_ack = 1'b0;
        reset_n       = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n       = 1'b1;
        byte_ready    = 1'b0;
        byte_data     = 8'h00;
        bus_write_ack = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus_write_req, bus_addr, bus_wdata, busy, overrun, drop_count} !== 75'd0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b addr=%h wdata=%h busy=%b ovr=%b drop=%h, want all 0",
                     bus_write_req, bus_addr, bus_wdata, busy, overrun, drop_count);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        // An ack with no pending request must have no effect.
        bus_write_ack = 1'b1;
        @(negedge clock);
        bus_write_ack = 1'b0;
        checks++;
        if (bus_write_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_ignored: got req=%b busy=%b, want 0 0", bus_write_req, busy);
        end
    endtask

    task automatic test_valid_packet();
        do_reset();
        send_byte(8'hA5);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL sync_busy: got busy=%b, want 1", busy);
        end
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        checks++;
        if (bus_write_req !== 1'b1 || bus_addr !== 32'h10000004 || bus_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL valid_write: got req=%b addr=%h wdata=%h, want 1 10000004 deadbeef",
                     bus_write_req, bus_addr, bus_wdata);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (bus_write_req !== 1'b1 || bus_addr !== 32'h10000004 || bus_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL valid_hold: got req=%b addr=%h wdata=%h, want 1 10000004 deadbeef",
                     bus_write_req, bus_addr, bus_wdata);
        end
        bus_write_ack = 1'b1;
        @(negedge clock);
        bus_write_ack = 1'b0;
        checks++;
        if (bus_write_req !== 1'b0 || busy !== 1'b0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL valid_ack: got req=%b busy=%b drop=%h, want 0 0 00",
                     bus_write_req, busy, drop_count);
        end
    endtask

    task automatic test_garbage_and_back_to_back();
        do_reset();
        send_byte(8'h00); send_byte(8'hFF);
        checks++;
        if (busy !== 1'b0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL garbage_ignored: got busy=%b drop=%h, want 0 00", busy, drop_count);
        end
        send_packet(32'h12345678, 32'h00000001);
        checks++;
        if (bus_write_req !== 1'b1 || bus_addr !== 32'h12345678 || bus_wdata !== 32'h00000001) begin
            errors++;
            $display("FAIL garbage_write: got req=%b addr=%h wdata=%h, want 1 12345678 00000001",
                     bus_write_req, bus_addr, bus_wdata);
        end
        bus_write_ack = 1'b1;
        @(negedge clock);
        bus_write_ack = 1'b0;
        checks++;
        if (bus_write_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL immediate_ack: got req=%b busy=%b, want 0 0", bus_write_req, busy);
        end
        // Second packet starts the cycle right after the write completes.
        send_packet(32'h0000ABC0, 32'h55AA1234);
        checks++;
        if (bus_write_req !== 1'b1 || bus_addr !== 32'h0000ABC0 || bus_wdata !== 32'h55AA1234) begin
            errors++;
            $display("FAIL back_to_back: got req=%b addr=%h wdata=%h, want 1 0000abc0 55aa1234",
                     bus_write_req, bus_addr, bus_wdata);
        end
        bus_write_ack = 1'b1;
        @(negedge clock);
        bus_write_ack = 1'b0;
    endtask

    task automatic test_misaligned();
        int req_seen;
        do_reset();
        req_seen = 0;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        checks++;
        if (busy !== 1'b0 || drop_count !== 8'd1) begin
            errors++;
            $display("FAIL misaligned_drop: got busy=%b drop=%h, want 0 01", busy, drop_count);
        end
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h11 * (i + 1));
            if (bus_write_req !== 1'b0 || busy !== 1'b0) req_seen++;
        end
        checks++;
        if (req_seen !== 0 || drop_count !== 8'd1) begin
            errors++;
            $display("FAIL misaligned_trailing: got active_cycles=%0d drop=%h, want 0 01",
                     req_seen, drop_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
        repeat (19) @(negedge clock);
        checks++;
        if (busy !== 1'b1 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL timeout_early: got busy=%b drop=%h at +20, want 1 00", busy, drop_count);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || drop_count !== 8'd1) begin
            errors++;
            $display("FAIL timeout_expire: got busy=%b drop=%h at +21, want 0 01", busy, drop_count);
        end

        // A byte on the expiry cycle wins and reloads the counter.
        do_reset();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
        repeat (19) @(negedge clock);
        send_byte(8'h03);
        checks++;
        if (busy !== 1'b1 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL timeout_byte_wins: got busy=%b drop=%h, want 1 00", busy, drop_count);
        end
        repeat (19) @(negedge clock);
        checks++;
        if (busy !== 1'b1 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL timeout_reload: got busy=%b drop=%h at +20, want 1 00", busy, drop_count);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || drop_count !== 8'd1) begin
            errors++;
            $display("FAIL timeout_reload_expire: got busy=%b drop=%h at +21, want 0 01",
                     busy, drop_count);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        send_packet(32'h20000000, 32'hCAFEF00D);
        repeat (25) @(negedge clock);
        checks++;
        if (bus_write_req !== 1'b1 || overrun !== 1'b0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL write_no_timeout: got req=%b ovr=%b drop=%h, want 1 0 00",
                     bus_write_req, overrun, drop_count);
        end
        send_byte(8'hA5);
        checks++;
        if (overrun !== 1'b1 || bus_write_req !== 1'b1 || bus_addr !== 32'h20000000 ||
            bus_wdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL overrun_set: got ovr=%b req=%b addr=%h wdata=%h, want 1 1 20000000 cafef00d",
                     overrun, bus_write_req, bus_addr, bus_wdata);
        end
        // Ack and a sync-valued byte together: write ends, byte is not parsed.
        bus_write_ack = 1'b1;
        send_byte(8'hA5);
        bus_write_ack = 1'b0;
        checks++;
        if (bus_write_req !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_ack_same_cycle: got req=%b busy=%b ovr=%b, want 0 0 1",
                     bus_write_req, busy, overrun);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_sticky: got ovr=%b busy=%b, want 1 0", overrun, busy);
        end
    endtask

    task automatic test_saturation_and_reset();
        do_reset();
        for (int n = 1; n <= 260; n++) begin
            send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
            if (n == 254) begin
                checks++;
                if (drop_count !== 8'hFE) begin
                    errors++;
                    $display("FAIL drop_count_254: got %h, want fe", drop_count);
                end
            end
        end
        checks++;
        if (drop_count !== 8'hFF) begin
            errors++;
            $display("FAIL drop_saturate: got %h, want ff", drop_count);
        end
        send_packet(32'h00000040, 32'h87654321);
        checks++;
        if (bus_write_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_write: got req=%b, want 1", bus_write_req);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus_write_req, bus_addr, bus_wdata, busy, overrun, drop_count} !== 75'd0) begin
            errors++;
            $display("FAIL reset_mid_write: got req=%b addr=%h wdata=%h busy=%b ovr=%b drop=%h, want all 0",
                     bus_write_req, bus_addr, bus_wdata, busy, overrun, drop_count);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (bus_write_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got req=%b busy=%b, want 0 0", bus_write_req, busy);
        end
    endtask

    initial begin
        test_reset();
        test_valid_packet();
        test_garbage_and_back_to_back();
        test_misaligned();
        test_timeout();
        test_overrun();
        test_saturation_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
